// File: rtl/rx_bitslip_word_align_pkg.sv
// ---------------------------------------------------------------------------
// rx_bitslip_word_align_pkg
//
// Purpose:
//   Shared definitions for the RX lane word-alignment logic. Holds the
//   alignment FSM state encoding, the default training word and a small
//   counter-width helper used to size the FSM counters.
//
// Contents:
//   align_state_e          FSM states ST_IDLE .. ST_FAIL
//   DEFAULT_TRAIN_PATTERN  training word as seen after bit-order reversal
//   clog2()                bits needed to hold values 0 .. value-1 (min 1)
// ---------------------------------------------------------------------------
package rx_bitslip_word_align_pkg;

  // Alignment FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  // 8'h68 has eight distinct rotations, so exactly one bitslip offset
  // produces a match and the search can never lock on a wrong phase.
  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'h68;

  // Width needed to count from 0 up to value-1; never narrower than 1 bit
  // so that degenerate parameter values still give a legal vector.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rx_bitslip_word_align.sv
// ---------------------------------------------------------------------------
// rx_bitslip_word_align
//
// Purpose:
//   Sits after the per-lane bit-order reversal stage of the RX IOD bit-align
//   path. Looks for the training word in the deserialised stream and pulses
//   bitslip_o to the IOD until the training word has been seen MATCH_CNT
//   valid cycles in a row, then reports lock. If the word cannot be found
//   within MAX_SLIPS bitslips the lane is reported as failed. The data word
//   itself is forwarded with one cycle of latency regardless of FSM state.
//
// Ports:
//   SCLK          in   1  lane fabric clock (single clock domain)
//   RESETN        in   1  asynchronous active-low reset
//   train_start   in   1  one-cycle pulse, (re)starts alignment from any state
//   rx_data_i     in   8  word from the reversal stage
//   rx_valid_i    in   1  qualifier for rx_data_i
//   bitslip_o     out  1  one-cycle bitslip request to the IOD
//   aligned_o     out  1  lock achieved, held until train_start or reset
//   align_fail_o  out  1  slip budget exhausted, held until train_start/reset
//   slip_count_o  out  4  bitslips issued in the current attempt
//   rx_data_o     out  8  rx_data_i delayed one cycle
//   rx_valid_o    out  1  rx_valid_i delayed one cycle
// ---------------------------------------------------------------------------
module rx_bitslip_word_align
  import rx_bitslip_word_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         MATCH_CNT     = 16,
  parameter int         SLIP_WAIT     = 8,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic       SCLK,
  input  logic       RESETN,
  input  logic       train_start,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       bitslip_o,
  output logic       aligned_o,
  output logic       align_fail_o,
  output logic [3:0] slip_count_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);

  // match_cnt has to reach MATCH_CNT itself; wait_cnt only runs up to
  // SLIP_WAIT-1 before handing back to CHECK.
  localparam int MATCH_W = clog2(MATCH_CNT + 1);
  localparam int WAIT_W  = clog2(SLIP_WAIT);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_CNT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [3:0]         SLIP_MAX   = 4'(MAX_SLIPS);

  align_state_e       state_q,      state_d;
  logic [MATCH_W-1:0] match_cnt_q,  match_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
  logic [3:0]         slip_cnt_q,   slip_cnt_d;
  logic               bitslip_q,    bitslip_d;
  logic               aligned_q,    aligned_d;
  logic               align_fail_q, align_fail_d;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q;

  // Next-state and output logic for the alignment search.
  // bitslip_d is raised on the CHECK->SLIP transition so that the
  // registered pulse is high exactly for the cycle the FSM sits in SLIP.
  // Because bitslip_d defaults to 0, a pulse already on the wire simply
  // ends after its single cycle even if train_start arrives at that moment.
  // train_start is tested before the state case so it overrides every
  // state, including the middle of a slip or a settle wait.
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    bitslip_d    = 1'b0;
    aligned_d    = aligned_q;
    align_fail_d = align_fail_q;

    if (train_start) begin
      state_d      = ST_CHECK;
      match_cnt_d  = '0;
      wait_cnt_d   = '0;
      slip_cnt_d   = '0;
      aligned_d    = 1'b0;
      align_fail_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        // Invalid cycles leave the match run untouched; only a valid
        // word can extend or break it.
        ST_CHECK: begin
          if (rx_valid_i) begin
            if (rx_data_i == TRAIN_PATTERN) begin
              match_cnt_d = match_cnt_q + 1'b1;
              if (match_cnt_q == MATCH_LAST) begin
                state_d   = ST_LOCKED;
                aligned_d = 1'b1;
              end
            end else begin
              match_cnt_d = '0;
              if (slip_cnt_q == SLIP_MAX) begin
                state_d      = ST_FAIL;
                align_fail_d = 1'b1;
              end else begin
                state_d   = ST_SLIP;
                bitslip_d = 1'b1;
              end
            end
          end
        end

        // The slip count only ever reaches SLIP_MAX through this state,
        // so holding at SLIP_MAX keeps slip_count_o saturating.
        ST_SLIP: begin
          if (slip_cnt_q != SLIP_MAX) begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end

        // The IOD needs time to settle after a slip, so SLIP_WAIT cycles
        // are spent here whatever rx_valid_i is doing. Together with the
        // SLIP cycle and at least one CHECK cycle this keeps consecutive
        // bitslip pulses SLIP_WAIT+2 or more cycles apart.
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        // Payload follows training, so the data is no longer inspected.
        ST_LOCKED: begin
          aligned_d = 1'b1;
        end

        ST_FAIL: begin
          align_fail_d = 1'b1;
        end

        default: begin
          state_d      = ST_IDLE;
          match_cnt_d  = '0;
          wait_cnt_d   = '0;
          slip_cnt_d   = '0;
          aligned_d    = 1'b0;
          align_fail_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and registered status flags. Reset is
  // asynchronous so a slip pulse in flight is cut off immediately.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      match_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      align_fail_q <= align_fail_d;
    end
  end

  // One-cycle data pipeline, independent of the alignment state.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_i;
      rx_valid_q <= rx_valid_i;
    end
  end

  assign bitslip_o    = bitslip_q;
  assign aligned_o    = aligned_q;
  assign align_fail_o = align_fail_q;
  assign slip_count_o = slip_cnt_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;

endmodule
